// File: rtl/i2c_write_master.sv
// i2c_write_master: I2C write-only master for the HDMI TX configuration path.
// Sends START, {slave_addr,W}, then 0..MAX_BYTES data bytes, checks each ACK
// slot and finishes with STOP. SCL is derived from the system clock through
// a quarter-bit tick divider. SDA/SCL are driven as open-drain enables.
// Optional feature macro: I2C_CLOCK_STRETCH_EN (honour slave clock stretching
// in the SCL-release quarters by watching scl_in).
module i2c_write_master #(
  parameter int CLK_DIV   = 62,
  parameter int MAX_BYTES = 4
) (
  input  logic                   clock,
  input  logic                   MR_n,
  input  logic                   start,
  input  logic [6:0]             slave_addr,
  input  logic [7:0]             byte_count,
  input  logic [MAX_BYTES*8-1:0] tx_data,
  input  logic                   sda_in,
  input  logic                   scl_in,
  output logic                   sda_oe,
  output logic                   scl_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   nack
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [7:0]    MAX_B8   = 8'(MAX_BYTES);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START_A = 4'd1;
  localparam logic [3:0] S_START_B = 4'd2;
  localparam logic [3:0] S_BIT     = 4'd3;
  localparam logic [3:0] S_ACK     = 4'd4;
  localparam logic [3:0] S_STOP_A  = 4'd5;
  localparam logic [3:0] S_STOP_B  = 4'd6;
  localparam logic [3:0] S_STOP_C  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]             state_r, state_s;
  logic [1:0]             q_r, q_s;
  logic [2:0]             bit_r, bit_s;
  logic [7:0]             shift_r, shift_s;
  logic [MAX_BYTES*8-1:0] data_r, data_s;
  logic [7:0]             count_r, count_s;
  logic [7:0]             sent_r, sent_s;
  logic [CW-1:0]          cnt_r;
  logic                   busy_s, done_s, nack_s;
  logic                   tick_s, hold_s;

  // Line enables {sda_oe, scl_oe} for a given state/quarter/current bit.
  function automatic logic [1:0] line_oe(input logic [3:0] st, input logic [1:0] q,
                                         input logic b);
    logic [1:0] oe;
    case (st)
      S_START_A: oe = 2'b10;
      S_START_B: oe = 2'b11;
      S_BIT:     oe = {~b, (q == 2'd0) || (q == 2'd3)};
      S_ACK:     oe = {1'b0, (q == 2'd0) || (q == 2'd3)};
      S_STOP_A:  oe = 2'b11;
      S_STOP_B:  oe = 2'b10;
      S_STOP_C:  oe = 2'b00;
      default:   oe = 2'b00;
    endcase
    return oe;
  endfunction

  assign tick_s = busy && (cnt_r == DIV_LAST);

`ifdef I2C_CLOCK_STRETCH_EN
  // Freeze the divider at zero while a slave keeps SCL low after we released it.
  always_comb begin
    hold_s = 1'b0;
    if ((((state_r == S_BIT) || (state_r == S_ACK)) && (q_r == 2'd1)) ||
        (state_r == S_STOP_B)) begin
      hold_s = ~scl_in && (cnt_r == CNT_ZERO);
    end else begin
      hold_s = 1'b0;
    end
  end
`else
  logic unused_scl_s;
  assign unused_scl_s = scl_in;
  assign hold_s = 1'b0;
`endif

  // Quarter-bit divider: runs only during a transaction, wraps on each tick.
  always_ff @(posedge clock or negedge MR_n) begin
    if (!MR_n) begin
      cnt_r <= CNT_ZERO;
    end else if (!busy || hold_s || tick_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    data_s  = data_r;
    count_s = count_r;
    sent_s  = sent_r;
    busy_s  = busy;
    done_s  = 1'b0;
    nack_s  = nack;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_START_A;
          q_s     = 2'd0;
          bit_s   = 3'd7;
          shift_s = {slave_addr, 1'b0};
          data_s  = tx_data;
          count_s = (byte_count > MAX_B8) ? MAX_B8 : byte_count;
          sent_s  = 8'd0;
          busy_s  = 1'b1;
          nack_s  = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START_A: begin
        if (tick_s) state_s = S_START_B;
        else        state_s = S_START_A;
      end
      S_START_B: begin
        if (tick_s) begin
          state_s = S_BIT;
          q_s     = 2'd0;
        end else begin
          state_s = S_START_B;
        end
      end
      S_BIT: begin
        if (tick_s && (q_r == 2'd3)) begin
          q_s = 2'd0;
          if (bit_r == 3'd0) begin
            state_s = S_ACK;
          end else begin
            bit_s   = bit_r - 3'd1;
            shift_s = {shift_r[6:0], 1'b0};
          end
        end else if (tick_s) begin
          q_s = q_r + 2'd1;
        end else begin
          q_s = q_r;
        end
      end
      S_ACK: begin
        if (tick_s && (q_r == 2'd2)) begin
          // SCL is high here; a released (high) SDA means the slave NACKed.
          nack_s = nack | sda_in;
          q_s    = 2'd3;
        end else if (tick_s && (q_r == 2'd3)) begin
          q_s = 2'd0;
          if (nack) begin
            state_s = S_STOP_A;
          end else if (sent_r < count_r) begin
            state_s = S_BIT;
            bit_s   = 3'd7;
            shift_s = data_r[7:0];
            data_s  = data_r >> 4'd8;
            sent_s  = sent_r + 8'd1;
          end else begin
            state_s = S_STOP_A;
          end
        end else if (tick_s) begin
          q_s = q_r + 2'd1;
        end else begin
          q_s = q_r;
        end
      end
      S_STOP_A: begin
        if (tick_s) state_s = S_STOP_B;
        else        state_s = S_STOP_A;
      end
      S_STOP_B: begin
        if (tick_s) state_s = S_STOP_C;
        else        state_s = S_STOP_B;
      end
      S_STOP_C: begin
        if (tick_s) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = S_STOP_C;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        done_s  = 1'b0;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State registers and registered pad/handshake outputs.
  always_ff @(posedge clock or negedge MR_n) begin
    if (!MR_n) begin
      state_r <= S_IDLE;
      q_r     <= 2'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      data_r  <= {(MAX_BYTES*8){1'b0}};
      count_r <= 8'd0;
      sent_r  <= 8'd0;
      sda_oe  <= 1'b0;
      scl_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state_r          <= state_s;
      q_r              <= q_s;
      bit_r            <= bit_s;
      shift_r          <= shift_s;
      data_r           <= data_s;
      count_r          <= count_s;
      sent_r           <= sent_s;
      {sda_oe, scl_oe} <= line_oe(state_s, q_s, shift_s[7]);
      busy             <= busy_s;
      done             <= done_s;
      nack             <= nack_s;
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Scoreboard bench for i2c_write_master (CLK_DIV=4, MAX_BYTES=4).
// A bus-level slave/monitor decodes the SDA/SCL enables, ACKs or NACKs,
// optionally stretches SCL, and checks each finished transaction against
// the expected record queued when the stimulus was issued.
module tb_i2c_write_master;

  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 4;

  logic        clock = 1'b0;
  logic        MR_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  slave_addr = 7'd0;
  logic [7:0]  byte_count = 8'd0;
  logic [31:0] tx_data = 32'd0;
  logic        sda_in, scl_in;
  logic        sda_oe, scl_oe, busy, done, nack;

  logic slave_low = 1'b0;
  logic hold = 1'b0;
  int   nack_at = 99;
  logic stretch_arm = 1'b0;

  assign sda_in = !(sda_oe || slave_low);
  assign scl_in = !(scl_oe || hold);

  i2c_write_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clock(clock), .MR_n(MR_n), .start(start), .slave_addr(slave_addr),
    .byte_count(byte_count), .tx_data(tx_data), .sda_in(sda_in), .scl_in(scl_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n;
    logic [47:0] b;
    int          cyc;
    logic        nk;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input int n, input logic [47:0] b, input int cyc, input logic nk);
    exp_t e;
    e.n = n; e.b = b; e.cyc = cyc; e.nk = nk;
    return e;
  endfunction

  // Bus monitor and slave model, sampled on the falling clock edge.
  initial begin
    logic       mscl, sda, scl_p, sda_p, ack_clk, chk_done;
    logic [7:0] shreg;
    logic [7:0] cap [0:15];
    int bitcnt, byte_idx, ncap, starts, stops, busy_cyc, hold_cnt;
    exp_t e;
    scl_p = 1'b1; sda_p = 1'b1; ack_clk = 1'b0; chk_done = 1'b0; shreg = 8'd0;
    bitcnt = 0; byte_idx = 0; ncap = 0; starts = 0; stops = 0; busy_cyc = 0; hold_cnt = 0;
    for (int i = 0; i < 16; i++) cap[i] = 8'd0;
    forever begin
      @(negedge clock);
      mscl = !scl_oe;
      sda  = sda_in;
      if (!MR_n) begin
        scl_p = 1'b1; sda_p = 1'b1; ack_clk = 1'b0; chk_done = 1'b0;
        bitcnt = 0; byte_idx = 0; ncap = 0; starts = 0; stops = 0; busy_cyc = 0;
        slave_low = 1'b0; hold = 1'b0; hold_cnt = 0;
      end else begin
        if (chk_done) begin
          check("done_pulse_width", {31'd0, done}, 32'd0);
          chk_done = 1'b0;
        end
        if (busy) busy_cyc++;
        if (scl_p && mscl && sda_p && !sda) begin
          starts++; bitcnt = 0; byte_idx = 0; ack_clk = 1'b0;
        end else if (scl_p && mscl && !sda_p && sda) begin
          stops++;
        end else if (!scl_p && mscl) begin
          if (bitcnt < 8) begin
            shreg = {shreg[6:0], sda};
            bitcnt++;
            if (bitcnt == 8 && ncap < 16) begin
              cap[ncap] = shreg;
              ncap++;
            end
          end else begin
            ack_clk = 1'b1; bitcnt = 0; byte_idx++;
          end
        end else if (scl_p && !mscl) begin
          if (ack_clk) begin
            slave_low = 1'b0; ack_clk = 1'b0;
          end else if (bitcnt == 8) begin
            slave_low = (byte_idx != nack_at);
          end
          if (stretch_arm && byte_idx == 1 && bitcnt == 3 && !hold) begin
            hold = 1'b1; hold_cnt = 0;
          end
        end
        if (hold && !scl_oe) begin
          hold_cnt++;
          if (hold_cnt > 50) hold = 1'b0;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("byte_count_on_bus", ncap, e.n);
            for (int i = 0; i < e.n && i < 16; i++)
              check($sformatf("bus_byte%0d", i), {24'd0, cap[i]}, {24'd0, e.b[8*i +: 8]});
            check("busy_cycles", busy_cyc, e.cyc);
            check("nack_flag", {31'd0, nack}, {31'd0, e.nk});
            check("start_count", starts, 1);
            check("stop_count", stops, 1);
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
          end
          chk_done = 1'b1;
          ncap = 0; starts = 0; stops = 0; busy_cyc = 0; byte_idx = 0; bitcnt = 0;
        end
        scl_p = mscl;
        sda_p = sda;
      end
    end
  end

  // Issue one transaction, queue its expectation and wait for it to finish.
  task automatic issue(input logic [6:0] a, input logic [7:0] cnt, input logic [31:0] d,
                       input int nk, input int extra, input exp_t e);
    nack_at = nk; slave_addr = a; byte_count = cnt; tx_data = d;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_nack_clear", {31'd0, nack}, 32'd0);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      start = (i == extra);
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      check("transaction_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int stretch_cyc;
`ifdef I2C_CLOCK_STRETCH_EN
    stretch_cyc = 502;
`else
    stretch_cyc = 452;
`endif
    repeat (3) @(negedge clock);
    #1 MR_n = 1'b1;
    @(negedge clock);
    check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_nack", {31'd0, nack}, 32'd0);

    // Two data bytes, all ACKed.
    issue(7'h39, 8'd2, 32'h0000_1041, 99, -1, mk(3, 48'h10_41_72, 452, 1'b0));
    // Address-only probe.
    issue(7'h39, 8'd0, 32'h0000_1041, 99, -1, mk(1, 48'h72, 164, 1'b0));
    // NACK on the first data byte: remaining bytes skipped.
    issue(7'h50, 8'd3, 32'h0033_2211, 1, -1, mk(2, 48'h11_A0, 308, 1'b1));
    repeat (10) @(negedge clock);
    check("nack_sticky", {31'd0, nack}, 32'd1);
    // Count clamped to MAX_BYTES; a second start while busy is ignored.
    issue(7'h2A, 8'd9, 32'hDDCC_BBAA, 99, 100, mk(5, 48'hDD_CC_BB_AA_54, 740, 1'b0));
    repeat (50) @(negedge clock);
    check("single_transaction", {31'd0, busy}, 32'd0);

    // Reset during address bit 5 releases both lines at once.
    nack_at = 99; slave_addr = 7'h39; byte_count = 8'd2; tx_data = 32'h0000_1041;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (94) @(negedge clock);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1 MR_n = 1'b0;
    #1;
    check("abort_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("abort_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1 MR_n = 1'b1;
    repeat (2) @(negedge clock);
    issue(7'h7F, 8'd1, 32'h0000_00A5, 99, -1, mk(2, 48'hA5_FE, 308, 1'b0));

    // Slave stretches SCL in Q1 of data bit 3 of the first data byte.
    stretch_arm = 1'b1;
    issue(7'h39, 8'd2, 32'h0000_1041, 99, -1, mk(3, 48'h10_41_72, stretch_cyc, 1'b0));
    stretch_arm = 1'b0;

    repeat (20) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Parametrised I2C write master for the HDMI TX configuration path. It replaces the fixed 2-byte, 100 kHz-clocked controller.
- Runs from the system clock with an internal SCL divider. Sends a 7-bit address plus W bit, then 0..MAX_BYTES data bytes.
- Samples real ACK/NACK from the slave and reports a sticky error. Drives open-drain-style output enables for SDA and SCL.
- Sits between the register-init sequencer (start/busy/done handshake) and the board SDA/SCL pads.

Parameters:
- CLK_DIV, 62, system clocks per quarter-bit tick. SCL = f_clk/(4*CLK_DIV), ~100 kHz at 25 MHz. Must be >=2.
- MAX_BYTES, 4, maximum data bytes per transaction. Must be >=1.

Ports:
- clock  input  1  system clock.
- MR_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- slave_addr  input  7  7-bit slave address; latched on accept.
- byte_count  input  8  number of data bytes; latched on accept; values >MAX_BYTES are clamped to MAX_BYTES.
- tx_data  input  MAX_BYTES*8  data bytes; byte i = tx_data[8i+7:8i]; byte 0 is sent first; latched on accept.
- sda_in  input  1  SDA pad level.
- scl_in  input  1  SCL pad level; used only with the optional feature.
- sda_oe  output  1  1 = pull SDA low, 0 = release (high).
- scl_oe  output  1  1 = pull SCL low, 0 = release.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse at transaction end.
- nack  output  1  sticky: a NACK was seen in the last transaction.

Behaviour:
- Reset (async, MR_n=0): sda_oe=0, scl_oe=0, busy=0, done=0, nack=0, state=IDLE, tick counter=0.
- Reset mid-transaction releases both lines immediately. No STOP is generated.
- Tick: a divider counts 0..CLK_DIV-1 and pulses a tick on wrap. It runs only while busy and is cleared on accept.
- All state advances happen on ticks, except accept and DONE.
- Accept: in IDLE with start=1, the module latches its inputs, clears nack, and sets busy=1 on the next edge. start while busy is ignored.
- Address byte = {slave_addr,1'b0}. Bytes are shifted MSB first.
- States (one tick each unless noted):
  - IDLE.
  - START_A: sda_oe=1, scl_oe=0.
  - START_B: scl_oe=1.
  - BIT, 4 ticks per bit:
    - Q0: scl_oe=1, sda_oe=~bit.
    - Q1: scl_oe=0.
    - Q2: SCL held high.
    - Q3: scl_oe=1.
  - ACK: same four quarters as BIT with sda_oe=0; sda_in is sampled at the Q2 tick (1 = NACK).
  - STOP_A: scl_oe=1, sda_oe=1.
  - STOP_B: scl_oe=0.
  - STOP_C: sda_oe=0.
  - DONE: done=1, busy=0, return to IDLE. DONE lasts one clock, not one tick.
- SDA changes only while SCL is driven low (Q0 and STOP_A), except START_A and STOP_C.
- After each ACK:
  - If NACK: set nack=1 and go to STOP_A. Remaining bytes are skipped.
  - Otherwise, if bytes sent < latched count: load the next byte and return to BIT.
  - Otherwise: go to STOP_A.
- byte_count=0 is an address-only probe: START, address, ACK, STOP.
- Duration with all ACKs: busy high for exactly (5+36*(N+1))*CLK_DIV cycles, where N = clamped count.
- On NACK at byte k (address = 0): busy high for (5+36*(k+1))*CLK_DIV cycles.
- nack holds until the next accepted start. done pulses on both success and NACK.

Optional Feature:
- I2C_CLOCK_STRETCH_EN defined:
  - In Q1 of BIT/ACK and in STOP_B, after releasing SCL, the tick counter holds at 0 while scl_in=0.
  - Q2 begins CLK_DIV cycles after scl_in is first seen high.
  - No other timing changes.
- Not defined: scl_in is ignored and timing is fixed.

Test Plan:
- CLK_DIV=4, addr=0x39, byte_count=2, tx_data bytes 0x41,0x10, slave ACKs all -> SDA sequence is START, 0x72, A, 0x41, A, 0x10, A, STOP. busy high exactly 452 cycles, done single pulse, nack=0.
- byte_count=0, slave ACKs -> START, 0x72, A, STOP. busy high 164 cycles with CLK_DIV=4.
- Slave NACKs the first data byte (byte_count=3) -> nack=1, STOP follows immediately after that ACK slot, bytes 1-2 never appear, busy high 308 cycles. The next accepted start clears nack.
- byte_count=9 with MAX_BYTES=4 -> exactly 4 data bytes sent. start pulsed again while busy -> ignored, single transaction.
- MR_n asserted during bit 5 of the address -> sda_oe=0, scl_oe=0, busy=0 in the same cycle. After release, a new start produces a clean transaction.
- With I2C_CLOCK_STRETCH_EN: the slave holds scl_in low 50 cycles in Q1 of data bit 3 -> SDA is stable throughout, busy is extended by 50 cycles, and the data is received correctly. Without the macro, the same stimulus leaves timing unchanged.
